// File: rtl/tile_buffer_responder.sv
// Responder side of the execution-unit buffer interface: NUM_BUFFERS tile buffers, each with its
// own write pointer and independent vector/matrix read pointers, so requesters only pulse enables.
module tile_buffer_responder #(
  parameter int DATA_WIDTH       = 8,
  parameter int TILE_WIDTH       = 256,
  parameter int TILE_ELEMS       = TILE_WIDTH / DATA_WIDTH,
  parameter int NUM_BUFFERS      = 8,
  parameter int TILES_PER_BUFFER = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   vec_read_enable,
  input  logic [4:0]                             vec_read_buffer_id,
  output logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0]  vec_read_tile,
  output logic                                   vec_read_valid,
  input  logic                                   mat_read_enable,
  input  logic [4:0]                             mat_read_buffer_id,
  output logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0]  mat_read_tile,
  output logic                                   mat_read_valid,
  input  logic                                   vec_write_enable,
  input  logic [4:0]                             vec_write_buffer_id,
  input  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0]  vec_write_tile,
  input  logic                                   buf_clear,
  input  logic [4:0]                             buf_clear_id,
  output logic [2:0]                             err
);

  localparam int PW = $clog2(TILES_PER_BUFFER) + 1;
  localparam int AW = PW - 1;
  localparam int BW = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
  localparam logic [PW-1:0] FULL   = PW'(TILES_PER_BUFFER);
  localparam logic [4:0]    NB_LIM = 5'(NUM_BUFFERS);

  typedef logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_t;

  tile_t tile_mem [NUM_BUFFERS][TILES_PER_BUFFER];

  logic [PW-1:0] wr_ptr_q     [NUM_BUFFERS];
  logic [PW-1:0] wr_ptr_d     [NUM_BUFFERS];
  logic [PW-1:0] count_q      [NUM_BUFFERS];
  logic [PW-1:0] count_d      [NUM_BUFFERS];
  logic [PW-1:0] vec_rd_ptr_q [NUM_BUFFERS];
  logic [PW-1:0] vec_rd_ptr_d [NUM_BUFFERS];
  logic [PW-1:0] mat_rd_ptr_q [NUM_BUFFERS];
  logic [PW-1:0] mat_rd_ptr_d [NUM_BUFFERS];

  tile_t      vec_read_tile_q, vec_read_tile_d;
  tile_t      mat_read_tile_q, mat_read_tile_d;
  logic       vec_read_valid_q, vec_read_valid_d;
  logic       mat_read_valid_q, mat_read_valid_d;
  logic [2:0] err_q, err_d;

  logic [BW-1:0] vec_b, mat_b, wr_b, clr_b;
  logic          vec_in_range, mat_in_range, wr_in_range, clr_in_range;
  logic          clr_hits_wr;
  logic [PW-1:0] wr_eff, cnt_eff;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;

  assign vec_b        = vec_read_buffer_id[BW-1:0];
  assign mat_b        = mat_read_buffer_id[BW-1:0];
  assign wr_b         = vec_write_buffer_id[BW-1:0];
  assign clr_b        = buf_clear_id[BW-1:0];
  assign vec_in_range = vec_read_buffer_id < NB_LIM;
  assign mat_in_range = mat_read_buffer_id < NB_LIM;
  assign wr_in_range  = vec_write_buffer_id < NB_LIM;
  assign clr_in_range = buf_clear_id < NB_LIM;
  assign clr_hits_wr  = buf_clear && clr_in_range && (clr_b == wr_b);

  // Read pointer wraps at the fill level so a stored vector can be re-streamed.
  function automatic logic [PW-1:0] next_rd(input logic [PW-1:0] ptr, input logic [PW-1:0] cnt);
    logic [PW-1:0] inc;
    inc = ptr + PW'(1);
    return (inc == cnt) ? '0 : inc;
  endfunction

  function automatic logic [PW-1:0] max_ptr(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    vec_rd_ptr_d     = vec_rd_ptr_q;
    mat_rd_ptr_d     = mat_rd_ptr_q;
    vec_read_valid_d = 1'b0;
    mat_read_valid_d = 1'b0;
    vec_read_tile_d  = '0;
    mat_read_tile_d  = '0;
    err_d            = '0;
    mem_we           = 1'b0;
    mem_waddr        = '0;
    wr_eff           = '0;
    cnt_eff          = '0;

    // Reads always answer, even when empty or out of range, so waiting consumers never stall.
    if (vec_read_enable) begin
      vec_read_valid_d = 1'b1;
      if (!vec_in_range) begin
        err_d[2] = 1'b1;
      end else if (count_q[vec_b] == '0) begin
        err_d[0] = 1'b1;
      end else begin
        vec_read_tile_d     = tile_mem[vec_b][vec_rd_ptr_q[vec_b][AW-1:0]];
        vec_rd_ptr_d[vec_b] = next_rd(vec_rd_ptr_q[vec_b], count_q[vec_b]);
      end
    end

    if (mat_read_enable) begin
      mat_read_valid_d = 1'b1;
      if (!mat_in_range) begin
        err_d[2] = 1'b1;
      end else if (count_q[mat_b] == '0) begin
        err_d[0] = 1'b1;
      end else begin
        mat_read_tile_d     = tile_mem[mat_b][mat_rd_ptr_q[mat_b][AW-1:0]];
        mat_rd_ptr_d[mat_b] = next_rd(mat_rd_ptr_q[mat_b], count_q[mat_b]);
      end
    end

    // Clear overrides any read-pointer advance above; a same-cycle write then lands at tile 0.
    if (buf_clear && clr_in_range) begin
      wr_ptr_d[clr_b]     = '0;
      count_d[clr_b]      = '0;
      vec_rd_ptr_d[clr_b] = '0;
      mat_rd_ptr_d[clr_b] = '0;
    end

    if (vec_write_enable) begin
      if (!wr_in_range) begin
        err_d[2] = 1'b1;
      end else begin
        wr_eff  = clr_hits_wr ? '0 : wr_ptr_q[wr_b];
        cnt_eff = clr_hits_wr ? '0 : count_q[wr_b];
        if (wr_eff == FULL) begin
          err_d[1] = 1'b1;
        end else begin
          mem_we         = 1'b1;
          mem_waddr      = wr_eff[AW-1:0];
          wr_ptr_d[wr_b] = wr_eff + PW'(1);
          count_d[wr_b]  = max_ptr(cnt_eff, wr_eff + PW'(1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q         <= '{default: '0};
      count_q          <= '{default: '0};
      vec_rd_ptr_q     <= '{default: '0};
      mat_rd_ptr_q     <= '{default: '0};
      vec_read_valid_q <= 1'b0;
      mat_read_valid_q <= 1'b0;
      vec_read_tile_q  <= '0;
      mat_read_tile_q  <= '0;
      err_q            <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      vec_rd_ptr_q     <= vec_rd_ptr_d;
      mat_rd_ptr_q     <= mat_rd_ptr_d;
      vec_read_valid_q <= vec_read_valid_d;
      mat_read_valid_q <= mat_read_valid_d;
      vec_read_tile_q  <= vec_read_tile_d;
      mat_read_tile_q  <= mat_read_tile_d;
      err_q            <= err_d;
    end
  end

  // Tile storage survives reset and clear; only pointers define what is visible.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      tile_mem[wr_b][mem_waddr] <= vec_write_tile;
    end
  end

  assign vec_read_tile  = vec_read_tile_q;
  assign vec_read_valid = vec_read_valid_q;
  assign mat_read_tile  = mat_read_tile_q;
  assign mat_read_valid = mat_read_valid_q;
  assign err            = err_q;

endmodule

// File: tb/tb_tile_buffer_responder.sv
// Directed bench for tile_buffer_responder: streaming reads, wrap, dual-port reads, empty/overflow/range
// errors, clear interactions and reset behaviour.
module tb_tile_buffer_responder;

  logic         clk;
  logic         rst;
  logic         vec_read_enable;
  logic [4:0]   vec_read_buffer_id;
  logic [255:0] vec_read_tile;
  logic         vec_read_valid;
  logic         mat_read_enable;
  logic [4:0]   mat_read_buffer_id;
  logic [255:0] mat_read_tile;
  logic         mat_read_valid;
  logic         vec_write_enable;
  logic [4:0]   vec_write_buffer_id;
  logic [255:0] vec_write_tile;
  logic         buf_clear;
  logic [4:0]   buf_clear_id;
  logic [2:0]   err;

  int total;
  int bad;

  tile_buffer_responder dut (
    .clk                 (clk),
    .rst                 (rst),
    .vec_read_enable     (vec_read_enable),
    .vec_read_buffer_id  (vec_read_buffer_id),
    .vec_read_tile       (vec_read_tile),
    .vec_read_valid      (vec_read_valid),
    .mat_read_enable     (mat_read_enable),
    .mat_read_buffer_id  (mat_read_buffer_id),
    .mat_read_tile       (mat_read_tile),
    .mat_read_valid      (mat_read_valid),
    .vec_write_enable    (vec_write_enable),
    .vec_write_buffer_id (vec_write_buffer_id),
    .vec_write_tile      (vec_write_tile),
    .buf_clear           (buf_clear),
    .buf_clear_id        (buf_clear_id),
    .err                 (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] mk(input int seed);
    logic [255:0] t;
    for (int i = 0; i < 32; i++) t[i*8 +: 8] = 8'(seed * 7 + i * 3 + 1);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic v, input logic [255:0] t, input logic [2:0] e);
    chk({tag, ".vvalid"}, 256'(vec_read_valid), 256'(v));
    chk({tag, ".vtile"}, vec_read_tile, t);
    chk({tag, ".err"}, 256'(err), 256'(e));
  endtask

  task automatic chk_mat(input string tag, input logic v, input logic [255:0] t);
    chk({tag, ".mvalid"}, 256'(mat_read_valid), 256'(v));
    chk({tag, ".mtile"}, mat_read_tile, t);
  endtask

  task automatic wr(input int b, input logic [255:0] t);
    vec_write_enable    = 1'b1;
    vec_write_buffer_id = 5'(b);
    vec_write_tile      = t;
    tick();
    vec_write_enable    = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    vec_read_enable = 1'b0; vec_read_buffer_id = '0;
    mat_read_enable = 1'b0; mat_read_buffer_id = '0;
    vec_write_enable = 1'b0; vec_write_buffer_id = '0; vec_write_tile = '0;
    buf_clear = 1'b0; buf_clear_id = '0;
    tick();
    tick();
    chk_vec("reset", 1'b0, '0, 3'b000);
    chk_mat("reset", 1'b0, '0);
    rst = 1'b0;
    tick();

    // Streaming reads with wrap on buffer 3.
    wr(3, mk(1)); wr(3, mk(2)); wr(3, mk(3));
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd3;
    tick(); chk_vec("t1.r0", 1'b1, mk(1), 3'b000);
    tick(); chk_vec("t1.r1", 1'b1, mk(2), 3'b000);
    tick(); chk_vec("t1.r2", 1'b1, mk(3), 3'b000);
    tick(); chk_vec("t1.wrap", 1'b1, mk(1), 3'b000);
    vec_read_enable = 1'b0;
    tick(); chk_vec("t1.idle", 1'b0, '0, 3'b000);

    // Dual-port same-buffer reads use independent pointers.
    wr(4, mk(4)); wr(4, mk(5));
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd4;
    mat_read_enable = 1'b1; mat_read_buffer_id = 5'd4;
    tick(); chk_vec("t2.p0", 1'b1, mk(4), 3'b000); chk_mat("t2.p0", 1'b1, mk(4));
    tick(); chk_vec("t2.p1", 1'b1, mk(5), 3'b000); chk_mat("t2.p1", 1'b1, mk(5));
    vec_read_enable = 1'b0; mat_read_enable = 1'b0;
    tick(); chk_mat("t2.idle", 1'b0, '0);

    // Empty buffer read.
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd5;
    tick(); chk_vec("t3.empty", 1'b1, '0, 3'b001);
    vec_read_enable = 1'b0;

    // Out-of-range ids: read, write, clear.
    mat_read_enable = 1'b1; mat_read_buffer_id = 5'd9;
    tick(); chk_mat("oor.read", 1'b1, '0); chk("oor.read.err", 256'(err), 256'(3'b100));
    mat_read_enable = 1'b0;
    wr(8, mk(77)); chk("oor.write.err", 256'(err), 256'(3'b100));
    buf_clear = 1'b1; buf_clear_id = 5'd20;
    tick(); chk("oor.clear.err", 256'(err), 256'(3'b000));
    buf_clear = 1'b0;

    // Fill buffer 0, overflow, then stream all 64 plus one wrap.
    for (int i = 0; i < 64; i++) wr(0, mk(100 + i));
    wr(0, mk(164)); chk("t4.overflow.err", 256'(err), 256'(3'b010));
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd0;
    for (int i = 0; i < 65; i++) begin
      tick(); chk("t4.stream", vec_read_tile, mk(100 + (i % 64)));
    end
    vec_read_enable = 1'b0;
    tick();

    // Clear plus write on the same buffer.
    wr(2, mk(20)); wr(2, mk(21)); wr(2, mk(22)); wr(2, mk(23));
    buf_clear = 1'b1; buf_clear_id = 5'd2;
    wr(2, mk(160));
    buf_clear = 1'b0;
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd2;
    tick(); chk_vec("t5.r0", 1'b1, mk(160), 3'b000);
    tick(); chk_vec("t5.r1", 1'b1, mk(160), 3'b000);
    vec_read_enable = 1'b0;

    // Clear plus read: read uses old pointer (buf 3 vec pointer sits at tile 1), then buffer is empty.
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd3;
    buf_clear = 1'b1; buf_clear_id = 5'd3;
    tick(); chk_vec("clr_rd.old", 1'b1, mk(2), 3'b000);
    buf_clear = 1'b0;
    tick(); chk_vec("clr_rd.after", 1'b1, '0, 3'b001);
    vec_read_enable = 1'b0;

    // Same-cycle read and write of an empty buffer: read sees old (empty) state.
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd5;
    wr(5, mk(50)); chk_vec("rbw.old", 1'b1, '0, 3'b001);
    tick(); chk_vec("rbw.new", 1'b1, mk(50), 3'b000);
    vec_read_enable = 1'b0;

    // Request accepted during reset yields no valid; reset empties the buffer.
    wr(6, mk(60));
    rst = 1'b1;
    vec_read_enable = 1'b1; vec_read_buffer_id = 5'd6;
    tick(); chk_vec("t6.rst", 1'b0, '0, 3'b000);
    rst = 1'b0;
    tick(); chk_vec("t6.after", 1'b1, '0, 3'b001);
    vec_read_enable = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
